serial_subtractor: RTL and testbench

- Bit-serial subtractor; the inverse-operation companion to the team's bit-serial adder.
- Captures two WIDTH-bit unsigned operands on a start request and shifts them LSB-first through a one-bit full subtractor with a registered borrow.
- Collects the difference bits into a parallel result and signals completion with a one-cycle done pulse.
- Sits beside the serial adder in the datapath. The same operand and start interface is used, so the two blocks are interchangeable under a common controller.

---
 rtl/serial_subtractor_if.sv | 30 +++
 rtl/serial_subtractor.sv | 91 +++++++++
 tb/tb_serial_subtractor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/start/result bundle shared by the serial subtractor and serial adder.
// The controller drives the master side and the arithmetic block drives the slave side.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start_top_i;
  logic [WIDTH-1:0] a_top_i;
  logic [WIDTH-1:0] b_top_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH:0]   final_diff_o;

  modport master (
    output start_top_i,
    output a_top_i,
    output b_top_i,
    input  busy_o,
    input  done_o,
    input  final_diff_o
  );

  modport slave (
    input  start_top_i,
    input  a_top_i,
    input  b_top_i,
    output busy_o,
    output done_o,
    output final_diff_o
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: LSB-first through a one-bit full subtractor with a registered borrow.
// Publishes {borrow_out, difference} with a one-cycle done pulse, WIDTH+1 clocks after start.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; operands captured on the accepting edge
// ST_SHIFT | one difference bit per clock, WIDTH clocks
// ST_DONE  | publish {borrow, result} and pulse done
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clock_top_i,
  input logic                reset_top_i,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             done;
  logic [WIDTH:0]   final_diff;

  logic diff_bit;
  logic borrow_nxt;

  always_comb begin
    diff_bit   = a_sr[0] ^ b_sr[0] ^ borrow;
    borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  end

  always_ff @(posedge clock_top_i) begin
    if (reset_top_i) begin
      state      <= ST_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow     <= 1'b0;
      count      <= '0;
      done       <= 1'b0;
      final_diff <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_top_i) begin
            a_sr   <= bus.a_top_i;
            b_sr   <= bus.b_top_i;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // difference enters at the MSB so the first bit lands in bit 0 after WIDTH shifts
          res_sr <= {diff_bit, res_sr[WIDTH-1:1]};
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          borrow <= borrow_nxt;
          count  <= count + 1'b1;
          if (count == LAST_BIT) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          final_diff <= {borrow, res_sr};
          done       <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o       = (state != ST_IDLE);
  assign bus.done_o       = done;
  assign bus.final_diff_o = final_diff;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus a random sweep
// against an arithmetic reference ({a<b, (a-b) mod 2^WIDTH}).
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clock_top_i (clk),
    .reset_top_i (rst),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int unsigned ai;
    int unsigned bi;
    int unsigned d;
    ai = a;
    bi = b;
    d  = (ai + (1 << WIDTH) - bi) % (1 << WIDTH);
    return {(ai < bi), d[WIDTH-1:0]};
  endfunction

  // One operation from E0 through the done cycle; optionally keep start high
  // (back-to-back) or poke start mid-operation (must be ignored).
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit hold, input bit poke, input bit detail);
    logic [WIDTH:0] exp;
    exp = ref_diff(a, b);
    bus.a_top_i     = a;
    bus.b_top_i     = b;
    bus.start_top_i = 1'b1;
    step();
    if (!hold) bus.start_top_i = 1'b0;
    bus.a_top_i = WIDTH'($urandom);
    bus.b_top_i = WIDTH'($urandom);
    if (detail) chk("busy_after_start", 32'(bus.busy_o), 32'd1);
    for (int k = 1; k <= WIDTH; k++) begin
      if (poke) bus.start_top_i = (k == 3);
      if (k % 2 == 0) begin
        bus.a_top_i = WIDTH'($urandom);
        bus.b_top_i = WIDTH'($urandom);
      end
      step();
      if (detail) begin
        chk("done_low_during_op", 32'(bus.done_o), 32'd0);
        chk("busy_during_op", 32'(bus.busy_o), 32'd1);
      end
    end
    if (poke) bus.start_top_i = 1'b0;
    if (hold) begin
      bus.a_top_i = WIDTH'($urandom);
      bus.b_top_i = WIDTH'($urandom);
    end
    step();
    chk("done_pulse", 32'(bus.done_o), 32'd1);
    chk("result", 32'(bus.final_diff_o), 32'(exp));
    if (detail) chk("busy_low_at_done", 32'(bus.busy_o), 32'd0);
    if (!hold) begin
      bus.start_top_i = 1'b0;
      step();
      chk("done_single_cycle", 32'(bus.done_o), 32'd0);
      chk("busy_idle", 32'(bus.busy_o), 32'd0);
      chk("result_held", 32'(bus.final_diff_o), 32'(exp));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int done_seen;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.start_top_i = 1'b0;
    bus.a_top_i = '0;
    bus.b_top_i = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_busy", 32'(bus.busy_o), 32'd0);
    chk("reset_done", 32'(bus.done_o), 32'd0);
    chk("reset_result", 32'(bus.final_diff_o), 32'd0);

    // directed cases
    do_op(8'd200, 8'd55, 1'b0, 1'b0, 1'b1);
    chk("ref_200_55", 32'(ref_diff(8'd200, 8'd55)), 32'h091);
    do_op(8'd5, 8'd10, 1'b0, 1'b0, 1'b1);
    do_op(8'd0, 8'd1, 1'b0, 1'b0, 1'b1);
    do_op(8'd255, 8'd255, 1'b0, 1'b0, 1'b1);

    // back-to-back with start held high: done every WIDTH+2 clocks
    do_op(8'd100, 8'd1, 1'b1, 1'b0, 1'b1);
    do_op(8'd3, 8'd3, 1'b0, 1'b0, 1'b1);

    // start pulsed while busy is ignored
    do_op(8'd77, 8'd140, 1'b0, 1'b1, 1'b1);
    done_seen = 0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      step();
      if (bus.done_o) done_seen++;
    end
    chk("no_extra_done_after_poke", 32'(done_seen), 32'd0);

    // reset in the middle of SHIFT aborts without publishing
    bus.a_top_i = 8'd200;
    bus.b_top_i = 8'd55;
    bus.start_top_i = 1'b1;
    step();
    bus.start_top_i = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    chk("abort_done", 32'(bus.done_o), 32'd0);
    chk("abort_result", 32'(bus.final_diff_o), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      step();
      if (bus.done_o) done_seen++;
    end
    chk("no_done_after_abort", 32'(done_seen), 32'd0);
    chk("result_still_zero", 32'(bus.final_diff_o), 32'd0);
    do_op(8'd18, 8'd200, 1'b0, 1'b0, 1'b1);

    // random sweep, back-to-back
    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (n % 50 == 0) rb = ra;
      do_op(ra, rb, (n != 999), 1'b0, (n % 100 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
